// File: rtl/calc_seq_core_if.sv
// Request/response bundle for calc_seq_core: operation request in, status back.
// start is a request qualified by busy: it is taken on a rising edge where busy=0, and is dropped (never queued) while busy=1.
interface calc_seq_core_if #(
    parameter int W = 8
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         err;

    modport master (output start, op, a, b, input busy, done, err);
    modport slave  (input start, op, a, b, output busy, done, err);
endinterface

// File: rtl/calc_seq_core.sv
// Sequential four-function calculator with a circular result history.
// Define CALC_SEQ_DIV_EN to build the restoring divider; without it op=11 completes as an error.
module calc_seq_core #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    calc_seq_core_if.slave    bus,
    input  logic [AW-1:0]     rd_addr,
    output logic [2*W-1:0]    rd_data,
    output logic [1:0]        last_op,
    output logic [AW-1:0]     wr_ptr,
    output logic [AW:0]       count,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
`ifdef CALC_SEQ_DIV_EN
        , ST_DIV = 2'd3
`endif
    } state_t;

    state_t         state_q;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] res_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic [1:0]     last_op_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    count_q;
    logic [2*W-1:0] mem_q [DEPTH];

`ifdef CALC_SEQ_DIV_EN
    localparam int CW = $clog2(W);
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    rem_sh;
    logic [W:0]    rem_sub;
    logic          ge;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  quo_nx;

    // rem_sh < 2*b, so the sign bit of rem_sh-b is a valid borrow flag
    always_comb begin
        rem_sh  = {rem_q, quo_q[W-1]};
        rem_sub = rem_sh - {1'b0, b_q};
        ge      = ~rem_sub[W];
        rem_nx  = ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
        quo_nx  = {quo_q[W-2:0], ge};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            last_op_q <= 2'b00;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef CALC_SEQ_DIV_EN
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_q   <= ST_DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    last_op_q <= op_q;
                    case (op_q)
                        2'b00: res_q <= {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                        2'b01: res_q <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
                        2'b10: res_q <= {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
                        default: begin
`ifdef CALC_SEQ_DIV_EN
                            if (b_q != '0) begin
                                state_q   <= ST_DIV;
                                busy_q    <= 1'b1;
                                done_q    <= 1'b0;
                                last_op_q <= last_op_q;
                                rem_q     <= '0;
                                quo_q     <= a_q;
                                cnt_q     <= '0;
                            end else begin
                                err_q <= 1'b1;
                            end
`else
                            err_q <= 1'b1;
`endif
                        end
                    endcase
                end
`ifdef CALC_SEQ_DIV_EN
                ST_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        res_q     <= {rem_nx, quo_nx};
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        last_op_q <= op_q;
                    end
                end
`endif
                ST_DONE: begin
                    if (!err_q) begin
                        mem_q[wr_ptr_q] <= res_q;
                        wr_ptr_q        <= wr_ptr_q + 1'b1;
                        if (count_q != (AW+1)'(DEPTH)) count_q <= count_q + 1'b1;
                    end
                    // busy is low here, so a new request is taken back-to-back
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign rd_data   = mem_q[rd_addr];
    assign last_op   = last_op_q;
    assign wr_ptr    = wr_ptr_q;
    assign count     = count_q;
    assign dbg_state = state_q;
endmodule
